// File: rtl/exhaustive_vector_sweeper.sv
// Exhaustive stimulus sweeper: binary/Gray vector walk, hold, capture, MISR.
// Optional golden-response comparison is enabled with `define SWEEP_COMPARE_EN.
module exhaustive_vector_sweeper #(
    parameter int N_WIDTH = 5,
    parameter int OUT_WIDTH = 1,
    parameter int HOLD_CYCLES = 1,
    parameter int SIG_WIDTH = 16,
    parameter logic [SIG_WIDTH-1:0] SIG_POLY = 16'h1021
) (
    input  logic                 CK,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mode_gray,
    input  logic                 pause,
    output logic [N_WIDTH-1:0]   vec_out,
    input  logic [OUT_WIDTH-1:0] resp_in,
`ifdef SWEEP_COMPARE_EN
    input  logic [OUT_WIDTH-1:0] exp_in,
    output logic [N_WIDTH:0]     mismatch_count,
    output logic [N_WIDTH-1:0]   first_fail_vec,
    output logic                 fail_seen,
`endif
    output logic                 sample_valid,
    output logic [N_WIDTH-1:0]   sample_vec,
    output logic [OUT_WIDTH-1:0] sample_resp,
    output logic                 busy,
    output logic                 done,
    output logic [SIG_WIDTH-1:0] signature,
    output logic [N_WIDTH:0]     vec_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] APPLY = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [N_WIDTH-1:0] IDX_LAST = '1;

    logic [1:0]           state;
    logic [N_WIDTH-1:0]   idx;
    logic [N_WIDTH-1:0]   idx_next;
    logic [HW-1:0]        hold_cnt;
    logic                 gray;
    logic                 accept;
    logic                 capture;
    logic                 last;
    logic [SIG_WIDTH-1:0] resp_ext;
    logic [SIG_WIDTH-1:0] sig_next;

    function automatic logic [N_WIDTH-1:0] map_vec(
        input logic [N_WIDTH-1:0] i,
        input logic               g
    );
        return g ? (i ^ (i >> 1)) : i;
    endfunction

    assign accept   = start && (state != APPLY);
    assign capture  = (state == APPLY) && !pause && (hold_cnt == HOLD_LAST);
    assign last     = (idx == IDX_LAST);
    assign idx_next = idx + 1'b1;
    assign busy     = (state == APPLY);
    assign done     = (state == DONE);

    always_comb begin
        resp_ext = '0;
        resp_ext[OUT_WIDTH-1:0] = resp_in;
        sig_next = {signature[SIG_WIDTH-2:0], 1'b0}
                 ^ (signature[SIG_WIDTH-1] ? SIG_POLY : '0)
                 ^ resp_ext;
    end

    always_ff @(posedge CK) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            hold_cnt     <= '0;
            gray         <= 1'b0;
            vec_out      <= '0;
            sample_valid <= 1'b0;
            sample_vec   <= '0;
            sample_resp  <= '0;
            signature    <= '0;
            vec_count    <= '0;
        end else begin
            sample_valid <= 1'b0;
            if (accept) begin
                state     <= APPLY;
                idx       <= '0;
                hold_cnt  <= '0;
                gray      <= mode_gray;
                vec_out   <= '0;
                signature <= '0;
                vec_count <= '0;
            end else if (state == APPLY && !pause) begin
                if (capture) begin
                    hold_cnt     <= '0;
                    sample_valid <= 1'b1;
                    sample_vec   <= vec_out;
                    sample_resp  <= resp_in;
                    signature    <= sig_next;
                    vec_count    <= vec_count + 1'b1;
                    // The final vector stays on vec_out after the sweep ends.
                    if (last) begin
                        state <= DONE;
                    end else begin
                        idx     <= idx_next;
                        vec_out <= map_vec(idx_next, gray);
                    end
                end else begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end
        end
    end

`ifdef SWEEP_COMPARE_EN
    always_ff @(posedge CK) begin
        if (reset || accept) begin
            mismatch_count <= '0;
            first_fail_vec <= '0;
            fail_seen      <= 1'b0;
        end else if (capture && (resp_in != exp_in)) begin
            mismatch_count <= mismatch_count + 1'b1;
            if (!fail_seen) begin
                first_fail_vec <= vec_out;
                fail_seen      <= 1'b1;
            end
        end
    end
`endif

endmodule
